// File: rtl/lsu_rv32_pkg.sv
// lsu_rv32_pkg: shared size encodings, FSM states, strobe constants and alignment helper
package lsu_rv32_pkg;
  typedef enum logic [1:0] {SZ_BYTE = 2'b00, SZ_HALF = 2'b01, SZ_WORD = 2'b10, SZ_ILL = 2'b11} size_e;
  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_e;
  localparam logic [3:0] STRB_NONE = 4'b0000;
  localparam logic [3:0] STRB_BYTE = 4'b0001;
  localparam logic [3:0] STRB_HALF = 4'b0011;
  localparam logic [3:0] STRB_WORD = 4'b1111;
  function automatic logic is_aligned(input logic [1:0] size, input logic [1:0] off);
    return size == SZ_BYTE || (size == SZ_HALF && !off[0]) || (size == SZ_WORD && off == 2'b00);
  endfunction
endpackage

// File: rtl/lsu_rv32_if.sv
// lsu_rv32_if: EXU request/response and memory bus signals of the load/store unit
interface lsu_rv32_if #(parameter int DATA_LEN = 32);
  logic                req_valid, req_ready, req_wen;
  logic [DATA_LEN-1:0] req_addr, req_wdata;
  logic [1:0]          req_size;
  logic                resp_valid, resp_err;
  logic [DATA_LEN-1:0] resp_rdata;
  logic                mem_valid, mem_ready, mem_wen;
  logic [DATA_LEN-1:0] mem_addr, mem_wdata;
  logic [3:0]          mem_wstrb;
  logic                mem_rvalid, mem_err;
  logic [DATA_LEN-1:0] mem_rdata;
  modport slave (
    input  req_valid, req_wen, req_addr, req_wdata, req_size, mem_ready, mem_rvalid, mem_rdata, mem_err,
    output req_ready, resp_valid, resp_rdata, resp_err, mem_valid, mem_wen, mem_addr, mem_wdata, mem_wstrb
  );
  modport master (
    output req_valid, req_wen, req_addr, req_wdata, req_size, mem_ready, mem_rvalid, mem_rdata, mem_err,
    input  req_ready, resp_valid, resp_rdata, resp_err, mem_valid, mem_wen, mem_addr, mem_wdata, mem_wstrb
  );
endinterface

// File: rtl/lsu_store_align.sv
// lsu_store_align: replicates store data across byte lanes and builds the write strobes
module lsu_store_align import lsu_rv32_pkg::*; #(
  parameter int DATA_LEN = 32
) (
  input  logic                i_wen,
  input  logic [1:0]          i_size,
  input  logic [1:0]          i_off,
  input  logic [DATA_LEN-1:0] i_wdata,
  output logic [3:0]          o_wstrb,
  output logic [DATA_LEN-1:0] o_wdata
);
  assign o_wstrb = !i_wen ? STRB_NONE :
                   i_size == SZ_BYTE ? STRB_BYTE << i_off :
                   i_size == SZ_HALF ? STRB_HALF << i_off : STRB_WORD;
  assign o_wdata = i_size == SZ_BYTE ? {(DATA_LEN/8){i_wdata[7:0]}} :
                   i_size == SZ_HALF ? {(DATA_LEN/16){i_wdata[15:0]}} : i_wdata;
endmodule

// File: rtl/lsu_rv32.sv
// lsu_rv32: RV32 load/store unit bridging EXU accesses onto a word-addressed valid/ready bus
module lsu_rv32 import lsu_rv32_pkg::*; #(
  parameter int DATA_LEN = 32,
  parameter int TIMEOUT  = 255
) (
  input logic       clk,
  input logic       rst,
  lsu_rv32_if.slave bus
);
  localparam int CW = $clog2(TIMEOUT + 1);
  state_e              r_state, w_next;
  logic                r_wen, r_err;
  logic [1:0]          r_size;
  logic [DATA_LEN-1:0] r_addr, r_wdata, r_rdata;
  logic [CW-1:0]       r_cnt;
  logic                w_ok, w_to;
  assign w_ok = is_aligned(bus.req_size, bus.req_addr[1:0]);
  assign w_to = r_cnt == CW'(TIMEOUT - 1);
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  w_next = bus.req_valid ? (w_ok ? S_ISSUE : S_RESP) : S_IDLE;
      S_ISSUE: w_next = bus.mem_ready ? S_WAIT : S_ISSUE;
      S_WAIT:  w_next = (bus.mem_rvalid || w_to) ? S_RESP : S_WAIT;
      default: w_next = S_IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_wen   <= 1'b0;
      r_size  <= 2'b00;
      r_addr  <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
      r_err   <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == S_IDLE && bus.req_valid) begin
        r_wen   <= bus.req_wen;
        r_size  <= bus.req_size;
        r_addr  <= bus.req_addr;
        r_wdata <= bus.req_wdata;
        if (!w_ok) begin
          r_err   <= 1'b1;
          r_rdata <= '0;
        end
      end
      if (r_state == S_ISSUE) r_cnt <= '0;
      // a response arriving on the timeout cycle still counts as a response
      if (r_state == S_WAIT) begin
        r_cnt <= r_cnt + 1'b1;
        if (bus.mem_rvalid) begin
          r_err   <= bus.mem_err;
          r_rdata <= (r_wen || bus.mem_err) ? '0 : bus.mem_rdata >> {r_addr[1:0], 3'b000};
        end else if (w_to) begin
          r_err   <= 1'b1;
          r_rdata <= '0;
        end
      end
    end
  end
  lsu_store_align #(.DATA_LEN(DATA_LEN)) u_align (
    .i_wen   (r_wen),
    .i_size  (r_size),
    .i_off   (r_addr[1:0]),
    .i_wdata (r_wdata),
    .o_wstrb (bus.mem_wstrb),
    .o_wdata (bus.mem_wdata)
  );
  assign bus.req_ready  = r_state == S_IDLE;
  assign bus.mem_valid  = r_state == S_ISSUE;
  assign bus.mem_wen    = r_wen;
  assign bus.mem_addr   = {r_addr[DATA_LEN-1:2], 2'b00};
  assign bus.resp_valid = r_state == S_RESP;
  assign bus.resp_rdata = r_rdata;
  assign bus.resp_err   = r_err;
endmodule

// File: tb/tb_lsu_rv32.sv
// tb_lsu_rv32: directed self-checking bench for lsu_rv32 with a hand-driven bus
module tb_lsu_rv32;
  localparam int TO = 255;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int errs = 0;
  int n;
  always #5 clk = ~clk;
  lsu_rv32_if #(.DATA_LEN(32)) bus();
  lsu_rv32 #(.DATA_LEN(32), .TIMEOUT(TO)) dut (.clk(clk), .rst(rst), .bus(bus.slave));
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errs++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic req(input logic wen, input logic [31:0] addr, input logic [31:0] wdata, input logic [1:0] size);
    bus.req_wen   = wen;
    bus.req_addr  = addr;
    bus.req_wdata = wdata;
    bus.req_size  = size;
    bus.req_valid = 1'b1;
    chk("req_ready", {31'd0, bus.req_ready}, 32'd1);
    step();
    bus.req_valid = 1'b0;
  endtask
  task automatic bus_cycle(input logic [31:0] rdata, input logic err);
    bus.mem_ready = 1'b1;
    step();
    bus.mem_ready  = 1'b0;
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = rdata;
    bus.mem_err    = err;
    step();
    bus.mem_rvalid = 1'b0;
    bus.mem_err    = 1'b0;
  endtask
  initial begin
    bus.req_valid = 1'b0; bus.req_wen = 1'b0; bus.req_addr = '0; bus.req_wdata = '0; bus.req_size = 2'b00;
    bus.mem_ready = 1'b0; bus.mem_rvalid = 1'b0; bus.mem_rdata = '0; bus.mem_err = 1'b0;
    repeat (2) step();
    rst = 1'b0;
    chk("rst_ready", {31'd0, bus.req_ready}, 32'd1);
    chk("rst_resp", {31'd0, bus.resp_valid}, 32'd0);
    chk("rst_mvalid", {31'd0, bus.mem_valid}, 32'd0);
    chk("rst_rdata", bus.resp_rdata, 32'h0);
    chk("rst_err", {31'd0, bus.resp_err}, 32'd0);
    // word load, zero-wait bus: mem_valid at N+1, resp_valid at N+3
    req(1'b0, 32'h8000_0004, 32'h0, 2'b10);
    chk("ld_mvalid", {31'd0, bus.mem_valid}, 32'd1);
    chk("ld_addr", bus.mem_addr, 32'h8000_0004);
    chk("ld_wstrb", {28'd0, bus.mem_wstrb}, 32'h0);
    chk("ld_wen", {31'd0, bus.mem_wen}, 32'd0);
    chk("ld_busy", {31'd0, bus.req_ready}, 32'd0);
    bus.mem_ready = 1'b1;
    step();
    bus.mem_ready = 1'b0;
    chk("ld_mvalid_wait", {31'd0, bus.mem_valid}, 32'd0);
    chk("ld_resp_early", {31'd0, bus.resp_valid}, 32'd0);
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = 32'hDEAD_BEEF;
    step();
    bus.mem_rvalid = 1'b0;
    chk("ld_resp", {31'd0, bus.resp_valid}, 32'd1);
    chk("ld_rdata", bus.resp_rdata, 32'hDEAD_BEEF);
    chk("ld_err", {31'd0, bus.resp_err}, 32'd0);
    chk("resp_ready", {31'd0, bus.req_ready}, 32'd0);
    bus.req_valid = 1'b1;
    step();
    chk("resp_pulse", {31'd0, bus.resp_valid}, 32'd0);
    chk("resp_hold", bus.resp_rdata, 32'hDEAD_BEEF);
    chk("resp_no_accept", {31'd0, bus.mem_valid}, 32'd0);
    bus.req_valid = 1'b0;
    // store byte at lane 3
    req(1'b1, 32'h8000_0003, 32'h0000_005A, 2'b00);
    chk("sb_addr", bus.mem_addr, 32'h8000_0000);
    chk("sb_wstrb", {28'd0, bus.mem_wstrb}, 32'h8);
    chk("sb_wdata", bus.mem_wdata, 32'h5A5A_5A5A);
    chk("sb_wen", {31'd0, bus.mem_wen}, 32'd1);
    bus_cycle(32'hFFFF_FFFF, 1'b0);
    chk("sb_resp", {31'd0, bus.resp_valid}, 32'd1);
    chk("sb_err", {31'd0, bus.resp_err}, 32'd0);
    chk("sb_rdata", bus.resp_rdata, 32'h0);
    step();
    // half load from upper half
    req(1'b0, 32'h8000_0002, 32'h0, 2'b01);
    chk("lh_wstrb", {28'd0, bus.mem_wstrb}, 32'h0);
    bus_cycle(32'h1234_ABCD, 1'b0);
    chk("lh_rdata", bus.resp_rdata, 32'h0000_1234);
    chk("lh_err", {31'd0, bus.resp_err}, 32'd0);
    step();
    // timeout after 3 stalled issue cycles
    req(1'b0, 32'h8000_0008, 32'h0, 2'b10);
    repeat (3) begin
      chk("to_stall", {31'd0, bus.mem_valid}, 32'd1);
      step();
    end
    chk("to_stall_addr", bus.mem_addr, 32'h8000_0008);
    bus.mem_ready = 1'b1;
    step();
    bus.mem_ready = 1'b0;
    n = 0;
    while (!bus.resp_valid && n < 1000) begin
      step();
      n++;
    end
    chk("to_cycles", n, TO);
    chk("to_err", {31'd0, bus.resp_err}, 32'd1);
    chk("to_rdata", bus.resp_rdata, 32'h0);
    step();
    // rvalid on the timeout cycle wins
    req(1'b0, 32'h8000_000C, 32'h0, 2'b10);
    bus.mem_ready = 1'b1;
    step();
    bus.mem_ready = 1'b0;
    repeat (TO - 1) step();
    chk("tie_wait", {31'd0, bus.resp_valid}, 32'd0);
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = 32'hCAFE_F00D;
    step();
    bus.mem_rvalid = 1'b0;
    chk("tie_resp", {31'd0, bus.resp_valid}, 32'd1);
    chk("tie_rdata", bus.resp_rdata, 32'hCAFE_F00D);
    chk("tie_err", {31'd0, bus.resp_err}, 32'd0);
    step();
    // misaligned word: response at N+1, no bus access
    req(1'b0, 32'h8000_0001, 32'h0, 2'b10);
    chk("mis_mvalid", {31'd0, bus.mem_valid}, 32'd0);
    chk("mis_resp", {31'd0, bus.resp_valid}, 32'd1);
    chk("mis_err", {31'd0, bus.resp_err}, 32'd1);
    chk("mis_rdata", bus.resp_rdata, 32'h0);
    step();
    chk("mis_done", {31'd0, bus.resp_valid}, 32'd0);
    req(1'b1, 32'h8000_0003, 32'h0, 2'b01);
    chk("mish_resp", {31'd0, bus.resp_valid}, 32'd1);
    chk("mish_err", {31'd0, bus.resp_err}, 32'd1);
    step();
    req(1'b0, 32'h8000_0000, 32'h0, 2'b11);
    chk("ill_mvalid", {31'd0, bus.mem_valid}, 32'd0);
    chk("ill_err", {31'd0, bus.resp_err}, 32'd1);
    step();
    // store half and store word lanes
    req(1'b1, 32'h8000_0002, 32'h0000_BEEF, 2'b01);
    chk("sh_wstrb", {28'd0, bus.mem_wstrb}, 32'hC);
    chk("sh_wdata", bus.mem_wdata, 32'hBEEF_BEEF);
    bus_cycle(32'h0, 1'b0);
    chk("sh_err", {31'd0, bus.resp_err}, 32'd0);
    step();
    req(1'b1, 32'h8000_0010, 32'h1122_3344, 2'b10);
    chk("sw_addr", bus.mem_addr, 32'h8000_0010);
    chk("sw_wstrb", {28'd0, bus.mem_wstrb}, 32'hF);
    chk("sw_wdata", bus.mem_wdata, 32'h1122_3344);
    bus_cycle(32'h0, 1'b0);
    chk("sw_resp", {31'd0, bus.resp_valid}, 32'd1);
    step();
    // bus error forces rdata to zero
    req(1'b0, 32'h8000_0000, 32'h0, 2'b10);
    bus_cycle(32'h1234_5678, 1'b1);
    chk("be_err", {31'd0, bus.resp_err}, 32'd1);
    chk("be_rdata", bus.resp_rdata, 32'h0);
    step();
    req(1'b0, 32'h8000_0005, 32'h0, 2'b00);
    chk("lb_wstrb", {28'd0, bus.mem_wstrb}, 32'h0);
    bus_cycle(32'hAABB_CCDD, 1'b0);
    chk("lb_rdata", bus.resp_rdata, 32'h00AA_BBCC);
    chk("lb_err", {31'd0, bus.resp_err}, 32'd0);
    step();
    // stray rvalid in IDLE is ignored
    bus.mem_rvalid = 1'b1;
    step();
    bus.mem_rvalid = 1'b0;
    chk("stray_resp", {31'd0, bus.resp_valid}, 32'd0);
    chk("stray_ready", {31'd0, bus.req_ready}, 32'd1);
    // reset during WAIT abandons the access
    req(1'b0, 32'h8000_0000, 32'h0, 2'b10);
    bus.mem_ready = 1'b1;
    step();
    bus.mem_ready = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rr_mvalid", {31'd0, bus.mem_valid}, 32'd0);
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = 32'h5555_AAAA;
    step();
    bus.mem_rvalid = 1'b0;
    chk("rr_resp", {31'd0, bus.resp_valid}, 32'd0);
    chk("rr_ready", {31'd0, bus.req_ready}, 32'd1);
    chk("rr_rdata", bus.resp_rdata, 32'h0);
    chk("rr_err", {31'd0, bus.resp_err}, 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errs);
    $finish;
  end
endmodule

// File: doc/lsu_rv32.md
LSU_RV32 -- requirements
Module: lsu_rv32

Interface
REQ-001 Parameter DATA_LEN, default 32: data and address width in bits.
REQ-002 Parameter TIMEOUT, default 255: maximum cycles in WAIT before the block forces an error response.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 req_valid  input  1  EXU access request present.
REQ-006 req_ready  output  1  request accepted this cycle when high together with req_valid.
REQ-007 req_wen  input  1  1 = store, 0 = load.
REQ-008 req_addr  input  DATA_LEN  byte address (the EXU addr_load value).
REQ-009 req_wdata  input  DATA_LEN  store data, right-aligned.
REQ-010 req_size  input  2  access size: 00 = byte, 01 = half, 10 = word, 11 = illegal.
REQ-011 resp_valid  output  1  one-cycle pulse: access complete.
REQ-012 resp_rdata  output  DATA_LEN  load word shifted right by addr[1:0]*8; feeds EXU pre_data.
REQ-013 resp_err  output  1  qualifies resp_valid: misaligned, illegal size, bus error or timeout.
REQ-014 mem_valid  output  1  bus request.
REQ-015 mem_ready  input  1  bus accepts the request.
REQ-016 mem_wen  output  1  bus write enable.
REQ-017 mem_addr  output  DATA_LEN  word-aligned address, bits [1:0] = 0.
REQ-018 mem_wdata  output  DATA_LEN  lane-aligned store data.
REQ-019 mem_wstrb  output  4  byte-lane write strobes.
REQ-020 mem_rvalid  input  1  bus response: read data or write acknowledge.
REQ-021 mem_rdata  input  DATA_LEN  bus read data.
REQ-022 mem_err  input  1  bus error; qualified by mem_rvalid.

Function
REQ-023 FSM states: IDLE, ISSUE, WAIT, RESP.
REQ-024 req_ready is 1 only in IDLE.
REQ-025 IDLE, req_valid, aligned: latch wen, addr, wdata and size; go to ISSUE.
REQ-026 Alignment rule: byte is always aligned; half requires addr[0] = 0; word requires addr[1:0] = 0.
REQ-027 IDLE, req_valid, misaligned or size = 11: latch the request and go to RESP with err = 1; no bus access.
REQ-028 ISSUE: mem_valid = 1 with all mem_* fields stable; on mem_ready go to WAIT. mem_valid is 0 in every other state.
REQ-029 Store lanes:
  - byte: wstrb = 0001 << off, wdata = {4{wdata[7:0]}}
  - half: wstrb = 0011 << off, wdata = {2{wdata[15:0]}}
  - word: wstrb = 1111
  - loads drive wstrb = 0000
  - off = addr[1:0]
REQ-030 WAIT, mem_rvalid: capture (mem_rdata >> off*8) and mem_err; go to RESP.
REQ-031 Timeout counter: cleared on entry to WAIT; increments each WAIT cycle. If it reaches TIMEOUT without mem_rvalid, go to RESP with err = 1 and rdata = 0.
REQ-032 mem_rvalid and timeout in the same cycle: mem_rvalid wins.
REQ-033 RESP: resp_valid = 1 for exactly one cycle, then IDLE. A request presented in that cycle is not accepted (req_ready = 0).
REQ-034 resp_rdata and resp_err hold their last values until the next RESP; resp_rdata = 0 for stores and error responses.
REQ-035 Latency with a zero-wait bus: accept in cycle N, mem_valid in N+1, rvalid in N+2, resp_valid in N+3.
REQ-036 mem_rvalid outside WAIT is ignored.

Reset
REQ-037 rst high: on the next edge state = IDLE, counter = 0, and resp_valid, resp_err, resp_rdata and the latched request all = 0.
REQ-038 Reset mid-transaction abandons the access: no resp_valid, and mem_valid = 0 from the next cycle.

Structure
REQ-039 Shared package holds:
  - size encodings (SZ_BYTE, SZ_HALF, SZ_WORD)
  - FSM state encoding
  - strobe constants
REQ-040 One sub-module, lsu_store_align: combinational lane and strobe generation; the FSM stays in lsu_rv32.

Verification
REQ-041 Load word at 0x80000004, mem_rdata = 0xDEADBEEF, zero-wait bus -> resp_valid at N+3, resp_rdata = 0xDEADBEEF, resp_err = 0.
REQ-042 Store byte 0x5A at 0x80000003 -> mem_addr = 0x80000000, wstrb = 1000, mem_wdata = 0x5A5A5A5A; resp_valid, err = 0.
REQ-043 Load half at 0x80000002, mem_rdata = 0x1234ABCD -> resp_rdata = 0x00001234.
REQ-044 Load word at 0x80000001 -> no mem_valid, resp_valid at N+1, resp_err = 1.
REQ-045 Load, mem_ready held 3 cycles, no mem_rvalid for TIMEOUT cycles -> resp_err = 1 at the timeout.
REQ-046 rst asserted in WAIT, then mem_rvalid -> no resp_valid, state IDLE, req_ready = 1 after reset.
